// File: rtl/main_mem_responder.sv
// Byte-serial memory responder: byte RAM plus a 4-byte IO window (TX FIFO, RX FIFO, status, halt).
module main_mem_responder #(
    parameter int unsigned           ADDR_WIDTH      = 17,
    parameter int unsigned           BYTE_SIZE       = 8,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE         = 17'h1FFFC,
    parameter int unsigned           FIFO_DEPTH_LOG2 = 3
`ifdef MEM_INIT_EN
    ,
    parameter string                 INIT_FILE       = "test.data"
`endif
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ADDR_WIDTH-1:0] mem_vis_addr,
    input  logic [1:0]            mem_vis_signal,
    input  logic [BYTE_SIZE-1:0]  mem_writen_data,
    output logic [BYTE_SIZE-1:0]  mem_data,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    output logic                  halted
);

    localparam int unsigned DEPTH = 2 ** FIFO_DEPTH_LOG2;
    localparam int unsigned CW    = FIFO_DEPTH_LOG2 + 1;
    localparam int unsigned PW    = FIFO_DEPTH_LOG2;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    localparam logic [1:0] SIG_NOP       = 2'b00;
    localparam logic [1:0] SIG_READ_INST = 2'b01;
    localparam logic [1:0] SIG_READ_DATA = 2'b10;
    localparam logic [1:0] SIG_WRITE     = 2'b11;

    logic [BYTE_SIZE-1:0] ram [2 ** ADDR_WIDTH];

    logic [7:0]    tx_mem [DEPTH];
    logic [PW-1:0] tx_wr_ptr, tx_rd_ptr;
    logic [CW-1:0] tx_cnt, tx_cnt_nxt;
    logic          tx_overflow;

    logic [7:0]    rx_mem [DEPTH];
    logic [PW-1:0] rx_wr_ptr, rx_rd_ptr;
    logic [CW-1:0] rx_cnt;

    logic                 is_io, is_read, is_write, rd_data;
    logic [1:0]           io_off;
    logic                 tx_full, rx_empty;
    logic                 tx_push_req, tx_push, tx_pop, tx_ovf_set;
    logic                 rx_push, rx_pop, stat_clr, halt_set;
    logic [BYTE_SIZE-1:0] rd_byte;

    assign tx_full  = (tx_cnt == FULL_CNT);
    assign rx_empty = (rx_cnt == '0);
    assign rx_ready = (rx_cnt != FULL_CNT);
    assign tx_data  = tx_mem[tx_rd_ptr];

    // Access decode and FIFO handshakes
    always_comb begin
        is_io    = (mem_vis_addr >= IO_BASE);
        io_off   = 2'(mem_vis_addr - IO_BASE);
        is_write = (mem_vis_signal == SIG_WRITE);
        rd_data  = (mem_vis_signal == SIG_READ_DATA);
        is_read  = rd_data || (mem_vis_signal == SIG_READ_INST);

        tx_pop      = tx_valid && tx_ready;
        tx_push_req = is_io && is_write && (io_off == 2'd0);
        tx_push     = tx_push_req && (!tx_full || tx_pop);
        tx_ovf_set  = tx_push_req && !tx_push;
        tx_cnt_nxt  = tx_cnt + CW'(tx_push) - CW'(tx_pop);

        rx_push  = rx_valid && rx_ready;
        rx_pop   = is_io && rd_data && (io_off == 2'd1) && !rx_empty;
        stat_clr = is_io && rd_data && (io_off == 2'd2);
        halt_set = is_io && is_write && (io_off == 2'd3);
    end

    // Read-data mux; instruction fetches from the IO window return zero
    always_comb begin
        rd_byte = '0;
        if (!is_io) begin
            rd_byte = ram[mem_vis_addr];
        end else if (rd_data) begin
            case (io_off)
                2'd0:    rd_byte = BYTE_SIZE'(tx_cnt);
                2'd1:    rd_byte = rx_empty ? '0 : BYTE_SIZE'(rx_mem[rx_rd_ptr]);
                2'd2:    rd_byte = BYTE_SIZE'({5'b0, tx_overflow, rx_empty, tx_full});
                default: rd_byte = BYTE_SIZE'({7'b0, halted});
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (is_write && !is_io) ram[mem_vis_addr] <= mem_writen_data;
        if (tx_push) tx_mem[tx_wr_ptr] <= 8'(mem_writen_data);
        if (rx_push) rx_mem[rx_wr_ptr] <= rx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_data    <= '0;
            halted      <= 1'b0;
            tx_overflow <= 1'b0;
            tx_valid    <= 1'b0;
            tx_cnt      <= '0;
            tx_wr_ptr   <= '0;
            tx_rd_ptr   <= '0;
            rx_cnt      <= '0;
            rx_wr_ptr   <= '0;
            rx_rd_ptr   <= '0;
        end else begin
            if (is_read) mem_data <= rd_byte;
            if (halt_set) halted <= 1'b1;
            if (tx_ovf_set) tx_overflow <= 1'b1;
            else if (stat_clr) tx_overflow <= 1'b0;

            tx_cnt   <= tx_cnt_nxt;
            tx_valid <= (tx_cnt_nxt != '0);
            if (tx_push) tx_wr_ptr <= tx_wr_ptr + PW'(1);
            if (tx_pop)  tx_rd_ptr <= tx_rd_ptr + PW'(1);

            rx_cnt <= rx_cnt + CW'(rx_push) - CW'(rx_pop);
            if (rx_push) rx_wr_ptr <= rx_wr_ptr + PW'(1);
            if (rx_pop)  rx_rd_ptr <= rx_rd_ptr + PW'(1);
        end
    end

    logic unused_nop;
    assign unused_nop = (mem_vis_signal == SIG_NOP);

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed plus randomized bench for main_mem_responder against a queue-based reference model.
module tb_main_mem_responder;

    localparam logic [16:0] IO_BASE = 17'h1FFFC;
    localparam logic [1:0]  NOP = 2'b00, RI = 2'b01, RD = 2'b10, WR = 2'b11;

    logic        clk, rst_n;
    logic [16:0] mem_vis_addr;
    logic [1:0]  mem_vis_signal;
    logic [7:0]  mem_writen_data, mem_data, tx_data, rx_data;
    logic        tx_valid, tx_ready, rx_valid, rx_ready, halted;

    main_mem_responder dut (
        .clk(clk), .rst_n(rst_n),
        .mem_vis_addr(mem_vis_addr), .mem_vis_signal(mem_vis_signal),
        .mem_writen_data(mem_writen_data), .mem_data(mem_data),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .halted(halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    // Reference model state
    logic [7:0]  ram_m [logic [16:0]];
    logic [7:0]  txq [$];
    logic [7:0]  rxq [$];
    logic [16:0] waddrs [$];
    logic        ovf_m = 1'b0, halt_m = 1'b0;
    logic [7:0]  md_m = 8'h00;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%02h expected=%02h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        txq.delete();
        rxq.delete();
        ovf_m  = 1'b0;
        halt_m = 1'b0;
        md_m   = 8'h00;
    endtask

    // One clock edge of the memory-side contract, evaluated from pre-edge state
    task automatic model_edge(input logic [1:0] sig, input logic [16:0] addr, input logic [7:0] wd,
                              input logic txr, input logic rxv, input logic [7:0] rxd);
        int  txn, rxn, off;
        bit  io;
        txn = txq.size();
        rxn = rxq.size();
        io  = (addr >= IO_BASE);
        off = int'(addr) - int'(IO_BASE);
        if (sig == RI || sig == RD) begin
            if (!io)            md_m = ram_m[addr];
            else if (sig == RI) md_m = 8'h00;
            else if (off == 0)  md_m = 8'(txn);
            else if (off == 1)  md_m = (rxn > 0) ? rxq[0] : 8'h00;
            else if (off == 2)  md_m = {5'b0, ovf_m, rxn == 0, txn == 8};
            else                md_m = {7'b0, halt_m};
        end
        if (txn > 0 && txr) void'(txq.pop_front());
        if (sig == WR && !io) ram_m[addr] = wd;
        if (sig == WR && io && off == 0) begin
            if (txq.size() < 8) txq.push_back(wd);
            else                ovf_m = 1'b1;
        end
        if (sig == RD && io && off == 2) ovf_m = 1'b0;
        if (sig == RD && io && off == 1 && rxn > 0) void'(rxq.pop_front());
        if (rxv && rxn < 8) rxq.push_back(rxd);
        if (sig == WR && io && off == 3) halt_m = 1'b1;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, "/mem_data"}, mem_data, md_m);
        check({tag, "/tx_valid"}, 8'(tx_valid), 8'(txq.size() != 0));
        if (txq.size() != 0) check({tag, "/tx_data"}, tx_data, txq[0]);
        check({tag, "/rx_ready"}, 8'(rx_ready), 8'(rxq.size() < 8));
        check({tag, "/halted"}, 8'(halted), 8'(halt_m));
    endtask

    task automatic cyc(input logic [1:0] sig, input logic [16:0] addr, input logic [7:0] wd,
                       input logic txr, input logic rxv, input logic [7:0] rxd, input string tag);
        @(negedge clk);
        mem_vis_signal  = sig;
        mem_vis_addr    = addr;
        mem_writen_data = wd;
        tx_ready        = txr;
        rx_valid        = rxv;
        rx_data         = rxd;
        @(posedge clk);
        model_edge(sig, addr, wd, txr, rxv, rxd);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        int          k;
        logic [1:0]  s;
        logic [16:0] a;
        logic [7:0]  wd;
        logic [7:0]  img [4];

        rst_n = 1'b0;
        mem_vis_signal = NOP; mem_vis_addr = '0; mem_writen_data = '0;
        tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset/mem_data", mem_data, 8'h00);
        check("reset/tx_valid", 8'(tx_valid), 8'h00);
        check("reset/rx_ready", 8'(rx_ready), 8'h01);
        check("reset/halted", 8'(halted), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // RAM write then read
        cyc(WR, 17'h00010, 8'hA5, 0, 0, 0, "ram_wr");
        cyc(RD, 17'h00010, 8'h00, 0, 0, 0, "ram_rd");
        check("ram_rd_const", mem_data, 8'hA5);
        waddrs.push_back(17'h00010);

        // Streamed instruction fetch
        img[0] = 8'h13; img[1] = 8'h05; img[2] = 8'h00; img[3] = 8'h00;
        for (int i = 0; i < 4; i++) begin
            cyc(WR, 17'(i), img[i], 0, 0, 0, "preload");
            waddrs.push_back(17'(i));
        end
        for (int i = 0; i < 4; i++) begin
            cyc(RI, 17'(i), 8'h00, 0, 0, 0, "ifetch");
            check("ifetch_const", mem_data, img[i]);
        end
        cyc(NOP, 17'h00002, 8'h00, 0, 0, 0, "nop_hold");

        // TX overflow and drain
        for (int i = 0; i < 9; i++) cyc(WR, IO_BASE, 8'(8'h41 + i), 0, 0, 0, "tx_fill");
        cyc(RD, IO_BASE, 8'h00, 0, 0, 0, "tx_count");
        check("tx_count_const", mem_data, 8'h08);
        cyc(RD, IO_BASE + 17'd2, 8'h00, 0, 0, 0, "status1");
        check("status1_const", mem_data, 8'h07);
        cyc(RD, IO_BASE + 17'd2, 8'h00, 0, 0, 0, "status2");
        check("status2_const", mem_data, 8'h03);
        check("tx_head_const", tx_data, 8'h41);
        for (int i = 0; i < 9; i++) cyc(NOP, 17'h0, 8'h00, 1, 0, 0, "tx_drain");
        check("tx_drained", 8'(tx_valid), 8'h00);

        // RX pop, empty pop, instruction read has no side effect
        cyc(NOP, 17'h0, 8'h00, 1, 1, 8'h31, "rx_push");
        cyc(RD, IO_BASE + 17'd1, 8'h00, 1, 0, 0, "rx_pop");
        check("rx_pop_const", mem_data, 8'h31);
        cyc(RD, IO_BASE + 17'd1, 8'h00, 1, 0, 0, "rx_pop_empty");
        check("rx_empty_const", mem_data, 8'h00);
        cyc(RD, IO_BASE + 17'd2, 8'h00, 1, 0, 0, "rx_status");
        check("rx_status_const", mem_data, 8'h02);
        cyc(NOP, 17'h0, 8'h00, 1, 1, 8'h5C, "rx_push2");
        cyc(RI, IO_BASE + 17'd1, 8'h00, 1, 0, 0, "rx_ifetch");
        check("rx_ifetch_const", mem_data, 8'h00);
        cyc(RD, IO_BASE + 17'd1, 8'h00, 1, 0, 0, "rx_pop2");
        check("rx_pop2_const", mem_data, 8'h5C);

        // Randomized mix of RAM and IO traffic
        for (int i = 0; i < 400; i++) begin
            k  = int'($urandom_range(0, 9));
            wd = 8'($urandom);
            s  = NOP;
            a  = '0;
            case (k)
                0, 1: begin
                    s = WR;
                    a = 17'($urandom_range(0, 255));
                    waddrs.push_back(a);
                end
                2: begin
                    s = ($urandom_range(0, 1) == 0) ? RD : RI;
                    a = waddrs[$urandom_range(0, waddrs.size() - 1)];
                end
                3: s = NOP;
                4: begin s = WR; a = IO_BASE; end
                5: begin s = RD; a = IO_BASE + 17'd1; end
                6: begin s = RD; a = IO_BASE + 17'($urandom_range(0, 3)); end
                7: begin s = RI; a = IO_BASE + 17'($urandom_range(0, 3)); end
                8: begin s = WR; a = IO_BASE + 17'($urandom_range(1, 2)); end
                default: begin s = RD; a = IO_BASE + 17'd2; end
            endcase
            cyc(s, a, wd, $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1, 8'($urandom), "rand");
        end

        // Halt, then asynchronous reset mid-cycle
        cyc(WR, IO_BASE + 17'd3, 8'h00, 0, 0, 0, "halt");
        check("halt_const", 8'(halted), 8'h01);
        cyc(WR, IO_BASE, 8'h77, 0, 0, 0, "pre_reset_push");
        cyc(RD, IO_BASE + 17'd3, 8'h00, 0, 0, 0, "halt_read");
        check("halt_read_const", mem_data, 8'h01);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("mid_reset/halted", 8'(halted), 8'h00);
        check("mid_reset/tx_valid", 8'(tx_valid), 8'h00);
        check("mid_reset/mem_data", mem_data, 8'h00);
        check("mid_reset/rx_ready", 8'(rx_ready), 8'h01);
        @(negedge clk);
        rst_n = 1'b1;
        cyc(RD, 17'h00010, 8'h00, 0, 0, 0, "ram_survives");
        cyc(RD, IO_BASE + 17'd2, 8'h00, 0, 0, 0, "status_after_reset");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
